// File: rtl/and_reduce_seq_ctrl.sv
// and_reduce_seq_ctrl: WIDTH-bit AND reduction evaluated CHUNK bits per cycle
// through one shared AND chain, with valid/ready on both sides.
// Optional build macro AND_SEQ_EARLY_EXIT_EN: leave RUN as soon as a chunk
// reduces to 0 (y is unchanged, only cycles and latency differ).
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | reducing one chunk per cycle, LSB chunk first
// DONE  | result presented, waiting for out_ready

module and_reduce_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW = $clog2(NCHUNK + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic [CW-1:0]    cycles,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    cyc;
  logic             chunk_and;
  logic             last_chunk;

  assign chunk_and  = &shreg[CHUNK-1:0];
  assign last_chunk = (idx == CW'(NCHUNK - 1));

  // State register; reset wins over any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN: begin
        if (last_chunk) state_nxt = DONE;
`ifdef AND_SEQ_EARLY_EXIT_EN
        if (!chunk_and) state_nxt = DONE;
`endif
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, fold one chunk per RUN cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      acc   <= 1'b0;
      idx   <= '0;
      cyc   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= x;
            acc   <= 1'b1;
            idx   <= '0;
            cyc   <= '0;
          end
        end
        RUN: begin
          acc   <= acc & chunk_and;
          shreg <= shreg >> CHUNK;
          idx   <= idx + CW'(1);
          cyc   <= cyc + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // y and cycles are the live accumulator/counter; they only move on accept
  // and during RUN, so they hold through DONE and after the result is taken.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign y         = acc;
  assign cycles    = cyc;

endmodule

// File: tb/tb_and_reduce_seq_ctrl.sv
// Directed bench for and_reduce_seq_ctrl: main 32/4 instance plus an 8/8
// instance for the single-chunk corner.

module tb_and_reduce_seq_ctrl;

`ifdef AND_SEQ_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic        y;
  logic [3:0]  cycles;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [7:0]  x1;
  logic        out_valid1;
  logic        out_ready1;
  logic        y1;
  logic        cycles1;
  logic        busy1;

  int n_total = 0;
  int n_bad   = 0;

  and_reduce_seq_ctrl #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .cycles(cycles), .busy(busy)
  );

  and_reduce_seq_ctrl #(.WIDTH(8), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .x(x1),
    .out_valid(out_valid1), .out_ready(out_ready1), .y(y1), .cycles(cycles1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present xv for one edge from IDLE, then count edges until out_valid.
  task automatic run_op(input logic [31:0] xv, output int n);
    x        = xv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; x1 = '0; out_ready1 = 1'b1;
    tick(); tick();
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_busy", busy, 0);

    // all ones
    out_ready = 1'b1;
    x = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    chk("run_out_valid", out_valid, 0);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("ones_lat", n, 8);
    chk("ones_y", y, 1);
    chk("ones_cycles", cycles, 8);
    tick();
    chk("ones_rel_valid", out_valid, 0);
    chk("ones_rel_ready", in_ready, 1);
    chk("ones_rel_y", y, 1);
    chk("ones_rel_cycles", cycles, 8);

    // zero in first chunk
    run_op(32'hFFFF_FFFE, n);
    chk("lo0_lat", n, EE ? 1 : 8);
    chk("lo0_y", y, 0);
    chk("lo0_cycles", cycles, EE ? 1 : 8);
    tick();

    // zero in last chunk
    run_op(32'h7FFF_FFFF, n);
    chk("hi0_lat", n, 8);
    chk("hi0_y", y, 0);
    chk("hi0_cycles", cycles, 8);
    tick();

    // backpressure in DONE with an ignored operand pulse
    out_ready = 1'b0;
    run_op(32'hFFFF_FFFF, n);
    chk("bp_lat", n, 8);
    in_valid = 1'b1; x = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_y", y, 1);
      chk("bp_cycles", cycles, 8);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_ready", in_ready, 1);
    tick();
    chk("bp_not_captured", busy, 0);
    chk("bp_y_kept", y, 1);

    // reset during RUN at idx=3
    x = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_cycles", cycles, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_state", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_cycles", cycles, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    chk("mid_rst_stay", out_valid, 0);
    run_op(32'hFFFF_FFFF, n);
    chk("post_rst_lat", n, 8);
    chk("post_rst_y", y, 1);
    chk("post_rst_cycles", cycles, 8);
    tick();

    // back-to-back with in_valid held high
    x = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    x = 32'h0;
    n = 0;
    while (!out_valid && n < 40) begin
      chk("b2b_ready_run", in_ready, 0);
      tick();
      n++;
    end
    chk("b2b1_lat", n, 8);
    chk("b2b1_y", y, 1);
    chk("b2b1_ready_done", in_ready, 0);
    tick();
    chk("b2b_idle_ready", in_ready, 1);
    chk("b2b_idle_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    chk("b2b2_accept", busy, 1);
    chk("b2b2_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("b2b2_lat", n, EE ? 1 : 8);
    chk("b2b2_y", y, 0);
    chk("b2b2_cycles", cycles, EE ? 1 : 8);
    tick();
    chk("b2b2_rel", in_ready, 1);

    // single-chunk instance
    x1 = 8'hFF; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("c1_busy", busy1, 1);
    chk("c1_valid0", out_valid1, 0);
    tick();
    chk("c1_valid", out_valid1, 1);
    chk("c1_y", y1, 1);
    chk("c1_cycles", cycles1, 1);
    tick();
    chk("c1_rel", in_ready1, 1);
    x1 = 8'h7F; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    chk("c1z_valid", out_valid1, 1);
    chk("c1z_y", y1, 0);
    chk("c1z_cycles", cycles1, 1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
